// File: rtl/arcade_input_map.sv
// arcade_input_map: joystick/keyboard merge, rotation, opposing-direction cleanup and coin pulse shaping (autofire via ARCADE_INPUT_AUTOFIRE_EN)
module arcade_input_map #(
  parameter int NUM_PLAYERS = 2,
  parameter int COIN_PULSE  = 8,
  parameter int AF_PERIOD   = 4
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic                       vblank,
  input  logic [1:0]                 rotate,
  input  logic [7:0]                 kbjoy,
  input  logic [8*NUM_PLAYERS-1:0]   joy,
  output logic [4*NUM_PLAYERS-1:0]   dir,
  output logic [NUM_PLAYERS-1:0]     fire,
  output logic [NUM_PLAYERS-1:0]     start,
  output logic                       coin
);
  typedef enum logic [1:0] {IDLE, PULSE, HOLD} coin_st_t;
  coin_st_t st_d, st_q;
  logic vblank_q, tick, coin_src, coin_in_q, armed_d, armed_q, go;
  logic [1:0] rot_d, rot_q;
  logic [7:0] cnt_d, cnt_q;
  logic [4*NUM_PLAYERS-1:0] dir_d, dir_q;
  logic [NUM_PLAYERS-1:0] fire_d, fire_q, start_d, start_q, af_term;
  assign tick  = vblank & ~vblank_q;
  assign dir   = dir_q;
  assign fire  = fire_q;
  assign start = start_q;
  assign coin  = st_q == PULSE;
  // v and result are {right, left, down, up}; rotate then drop contradictory pairs
  function automatic logic [3:0] map_dir(input logic [3:0] v, input logic [1:0] rt);
    logic u, d, l, r, mu, md, ml, mr;
    {r, l, d, u} = v;
    mu = rt == 2'b00 ? u : rt == 2'b01 ? r : rt == 2'b10 ? d : l;
    mr = rt == 2'b00 ? r : rt == 2'b01 ? d : rt == 2'b10 ? l : u;
    md = rt == 2'b00 ? d : rt == 2'b01 ? l : rt == 2'b10 ? u : r;
    ml = rt == 2'b00 ? l : rt == 2'b01 ? u : rt == 2'b10 ? r : d;
    return {mr & ~ml, ml & ~mr, md & ~mu, mu & ~md};
  endfunction
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  logic [7:0] af_cnt_d [NUM_PLAYERS];
  logic [7:0] af_cnt_q [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] af_ph_d, af_ph_q, af_act_d, af_act_q;
  // autofire phase: set on first held cycle, flips every AF_PERIOD ticks, cleared on release
  always_comb begin
    for (int n = 0; n < NUM_PLAYERS; n++) begin
      af_act_d[n] = joy[8*n+5];
      af_ph_d[n]  = !joy[8*n+5] ? 1'b0 : !af_act_q[n] ? 1'b1 :
                    (tick && af_cnt_q[n] == 8'(AF_PERIOD - 1)) ? ~af_ph_q[n] : af_ph_q[n];
      af_cnt_d[n] = (!joy[8*n+5] || !af_act_q[n]) ? 8'd0 : !tick ? af_cnt_q[n] :
                    af_cnt_q[n] == 8'(AF_PERIOD - 1) ? 8'd0 : af_cnt_q[n] + 8'd1;
    end
    af_term = af_ph_d;
  end
  // autofire state registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      af_ph_q  <= '0;
      af_act_q <= '0;
      for (int n = 0; n < NUM_PLAYERS; n++) af_cnt_q[n] <= 8'd0;
    end else begin
      af_ph_q  <= af_ph_d;
      af_act_q <= af_act_d;
      for (int n = 0; n < NUM_PLAYERS; n++) af_cnt_q[n] <= af_cnt_d[n];
    end
  end
`else
  // without autofire the button simply acts as a second fire button
  always_comb begin
    af_term = '0;
    for (int n = 0; n < NUM_PLAYERS; n++) af_term[n] = joy[8*n+5];
  end
`endif
  // per-player merge of keyboard into player 0, rotation, fire/start and coin source
  always_comb begin
    rot_d    = tick ? rotate : rot_q;
    coin_src = kbjoy[3];
    dir_d    = '0;
    fire_d   = '0;
    start_d  = '0;
    for (int n = 0; n < NUM_PLAYERS; n++) begin
      dir_d[4*n +: 4] = map_dir({joy[8*n], joy[8*n+1], joy[8*n+2], joy[8*n+3]} | (n == 0 ? kbjoy[7:4] : 4'b0), rot_q);
      fire_d[n]  = joy[8*n+4] | af_term[n] | (n == 0 && kbjoy[0]);
      start_d[n] = joy[8*n+6] | (n < 2 && kbjoy[1+n]);
      coin_src   = coin_src | joy[8*n+7];
    end
  end
  // coin FSM: armed only once the source has been seen low, so a coin held through reset never fires
  always_comb begin
    go      = st_q == IDLE && coin_in_q && armed_q;
    armed_d = ~coin_src | (armed_q & ~go);
    cnt_d   = go ? 8'd0 : (st_q == PULSE && tick && cnt_q != 8'hff) ? cnt_q + 8'd1 : cnt_q;
    st_d    = go ? PULSE : (st_q == PULSE && cnt_d == 8'(COIN_PULSE)) ? HOLD :
              (st_q == HOLD && !coin_in_q) ? IDLE : st_q;
  end
  // state and output registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vblank_q  <= 1'b0;
      rot_q     <= 2'b00;
      dir_q     <= '0;
      fire_q    <= '0;
      start_q   <= '0;
      coin_in_q <= 1'b0;
      armed_q   <= 1'b0;
      st_q      <= IDLE;
      cnt_q     <= 8'd0;
    end else begin
      vblank_q  <= vblank;
      rot_q     <= rot_d;
      dir_q     <= dir_d;
      fire_q    <= fire_d;
      start_q   <= start_d;
      coin_in_q <= coin_src;
      armed_q   <= armed_d;
      st_q      <= st_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_arcade_input_map.sv
// tb_arcade_input_map: vector table, directed coin/rotation/autofire sequences and randomized model check
module tb_arcade_input_map;
  localparam int NP = 2, CP = 3, AFP = 2;
  logic clk_sys = 1'b0, reset = 1'b1, vblank = 1'b0;
  logic [1:0] rotate = 2'b00;
  logic [7:0] kbjoy = 8'h00;
  logic [15:0] joy = 16'h0000;
  logic [7:0] dir;
  logic [1:0] fire, start;
  logic coin;
  int checks = 0, errors = 0;

  arcade_input_map #(.NUM_PLAYERS(NP), .COIN_PULSE(CP), .AF_PERIOD(AFP)) dut (
    .clk_sys(clk_sys), .reset(reset), .vblank(vblank), .rotate(rotate), .kbjoy(kbjoy),
    .joy(joy), .dir(dir), .fire(fire), .start(start), .coin(coin));

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [1:0]  rot;
    logic [7:0]  kb;
    logic [15:0] j;
    logic [7:0]  d;
    logic [1:0]  f;
    logic [1:0]  s;
  } vec_t;
  vec_t vt [11];

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    kbjoy = 8'h00; joy = 16'h0000; vblank = 1'b0;
    reset = 1'b1; step(); step();
    reset = 1'b0; step();
  endtask

  task automatic frame();
    vblank = 1'b1; step();
    vblank = 1'b0; repeat (5) step();
  endtask

  // runs n frames; counts ticks seen while coin is high and rising edges of coin
  task automatic coin_frames(input int n, output int ticks_hi, output int edges);
    logic prev;
    ticks_hi = 0; edges = 0; prev = coin;
    for (int f = 0; f < n; f++)
      for (int c = 0; c < 6; c++) begin
        vblank = (c == 0);
        if (c == 0 && coin) ticks_hi++;
        step();
        if (coin && !prev) edges++;
        prev = coin;
      end
    vblank = 1'b0;
  endtask

  // directions as compass angles 0 up,1 right,2 down,3 left; rotation k takes input angle a+k
  function automatic logic [3:0] m_dir(input logic [7:0] j, input logic [7:0] kb, input bit p0, input logic [1:0] rot);
    logic [3:0] in_a, out_a;
    in_a[0] = j[3] | (p0 & kb[4]);
    in_a[1] = j[0] | (p0 & kb[7]);
    in_a[2] = j[2] | (p0 & kb[5]);
    in_a[3] = j[1] | (p0 & kb[6]);
    for (int a = 0; a < 4; a++) out_a[a] = in_a[(a + int'(rot)) % 4];
    if (out_a[0] && out_a[2]) begin out_a[0] = 1'b0; out_a[2] = 1'b0; end
    if (out_a[1] && out_a[3]) begin out_a[1] = 1'b0; out_a[3] = 1'b0; end
    return {out_a[1], out_a[3], out_a[2], out_a[0]};
  endfunction

  initial begin
    int th, ed;
    logic [1:0] m_rot;
    logic m_vbq, tk;
    logic [7:0] e_dir;
    logic [1:0] e_fire, e_start;
    logic e_af;
    vt[0]  = '{2'b01, 8'h00, 16'h0001, 8'h01, 2'b00, 2'b00};
    vt[1]  = '{2'b00, 8'h10, 16'h0004, 8'h00, 2'b00, 2'b00};
    vt[2]  = '{2'b00, 8'h00, 16'h0900, 8'h90, 2'b00, 2'b00};
    vt[3]  = '{2'b10, 8'h80, 16'h0000, 8'h04, 2'b00, 2'b00};
    vt[4]  = '{2'b11, 8'h00, 16'h0208, 8'h18, 2'b00, 2'b00};
    vt[5]  = '{2'b00, 8'h07, 16'h0000, 8'h00, 2'b01, 2'b11};
    vt[6]  = '{2'b00, 8'h00, 16'h5040, 8'h00, 2'b10, 2'b11};
    vt[7]  = '{2'b01, 8'h00, 16'h0003, 8'h00, 2'b00, 2'b00};
    vt[8]  = '{2'b00, 8'h00, 16'h0020, 8'h00, 2'b01, 2'b00};
    vt[9]  = '{2'b10, 8'h20, 16'h0002, 8'h09, 2'b00, 2'b00};
    vt[10] = '{2'b11, 8'hC0, 16'h0000, 8'h00, 2'b00, 2'b00};

    kbjoy = 8'hFF; joy = 16'hFFFF; rotate = 2'b01;
    step(); step();
    chk("reset_dir", dir, 8'h00);
    chk("reset_fire", fire, 2'b00);
    chk("reset_start", start, 2'b00);
    chk("reset_coin", coin, 1'b0);
    rotate = 2'b00;
    do_reset();

    for (int i = 0; i < 11; i++) begin
      kbjoy = 8'h00; joy = 16'h0000; rotate = vt[i].rot;
      vblank = 1'b1; step();
      vblank = 1'b0; step();
      kbjoy = vt[i].kb; joy = vt[i].j;
      step();
      chk($sformatf("vec%0d_dir", i), dir, vt[i].d);
      chk($sformatf("vec%0d_fire", i), fire, vt[i].f);
      chk($sformatf("vec%0d_start", i), start, vt[i].s);
    end

    do_reset();
    kbjoy[4] = 1'b1; step();
    chk("rot_up_before", dir, 8'h01);
    rotate = 2'b10; step(); step();
    chk("rot_midframe", dir, 8'h01);
    vblank = 1'b1; step();
    chk("rot_at_tick", dir, 8'h01);
    vblank = 1'b0; step();
    chk("rot_after_tick", dir, 8'h02);

    do_reset();
    kbjoy[3] = 1'b1;
    coin_frames(10, th, ed);
    chk("coin_ticks", th, CP);
    chk("coin_pulses", ed, 1);
    chk("coin_held_low", coin, 1'b0);
    kbjoy = 8'h00;
    coin_frames(2, th, ed);
    chk("coin_release_pulses", ed, 0);
    joy[15] = 1'b1;
    coin_frames(6, th, ed);
    chk("coin_repress_ticks", th, CP);
    chk("coin_repress_pulses", ed, 1);
    joy = 16'h0000;

    do_reset();
    kbjoy[3] = 1'b1; step(); step();
    chk("coin_on", coin, 1'b1);
    frame();
    chk("coin_still_on", coin, 1'b1);
    vblank = 1'b1; reset = 1'b1; step();
    chk("coin_reset_drop", coin, 1'b0);
    reset = 1'b0; vblank = 1'b0;
    coin_frames(5, th, ed);
    chk("coin_held_after_reset", ed, 0);
    kbjoy = 8'h00; repeat (3) step();
    kbjoy[3] = 1'b1;
    coin_frames(5, th, ed);
    chk("coin_after_rearm_pulses", ed, 1);
    chk("coin_after_rearm_ticks", th, CP);

    do_reset();
    joy[13] = 1'b1; step();
    for (int k = 0; k < 8; k++) begin
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      e_af = ((k / AFP) % 2) == 0;
`else
      e_af = 1'b1;
`endif
      chk($sformatf("autofire_frame%0d", k), fire[1], e_af);
      frame();
    end
    joy = 16'h0000; step();
    chk("autofire_release", fire, 2'b00);

    do_reset();
    m_rot = 2'b00; m_vbq = 1'b0;
    repeat (300) begin
      rotate = 2'($urandom);
      vblank = $urandom_range(0, 3) == 0;
      kbjoy = 8'($urandom) & 8'hF7;
      joy = 16'($urandom) & 16'h7F7F;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      joy = joy & 16'hDFDF;
`endif
      e_dir = {m_dir(joy[15:8], kbjoy, 1'b0, m_rot), m_dir(joy[7:0], kbjoy, 1'b1, m_rot)};
      e_fire = {joy[12] | joy[13], joy[4] | joy[5] | kbjoy[0]};
      e_start = {joy[14] | kbjoy[2], joy[6] | kbjoy[1]};
      tk = vblank & ~m_vbq;
      step();
      if (tk) m_rot = rotate;
      m_vbq = vblank;
      chk("rand_dir", dir, e_dir);
      chk("rand_fire", fire, e_fire);
      chk("rand_start", start, e_start);
      chk("rand_coin", coin, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
